// File: rtl/snn_step_sequencer.sv
// Timestep sequencer for snn_core: pulls one event vector per issued step, gates the
// core with a step enable and buffers the resulting spike rows in a small output FIFO.
module snn_step_sequencer #(
  parameter int F           = 48,
  parameter int N           = 96,
  parameter int T_W         = 16,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic [T_W-1:0] t_len,
  output logic           busy,
  output logic           done,
  input  logic           ev_valid,
  input  logic [F-1:0]   ev_data,
  output logic           ev_ready,
  output logic           core_clr,
  output logic           core_en,
  output logic [F-1:0]   core_event_vec,
  input  logic [N-1:0]   core_spikes,
  output logic           sp_valid,
  output logic [N-1:0]   sp_data,
  output logic           sp_last,
  input  logic           sp_ready,
  output logic [T_W-1:0] t_idx
);

  localparam int AW = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [T_W-1:0] t_len_q, t_len_d;
  logic [T_W-1:0] t_idx_q, t_idx_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           ev_ready_q, ev_ready_d;
  logic           core_clr_q, core_clr_d;
  logic           core_en_q, core_en_d;
  logic [F-1:0]   core_event_vec_q, core_event_vec_d;
  logic           en_last_q, en_last_d;
  logic           cap_q, cap_d;
  logic           cap_last_q, cap_last_d;
  logic [N:0]     mem_q [OFIFO_DEPTH];
  logic [N:0]     mem_d [OFIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           sp_valid_q, sp_valid_d;

  logic           issue_s;
  logic           last_s;
  logic           rd_s;
  logic [1:0]     inflight_s;
  logic [1:0]     inflight_d_s;
  logic [CW:0]    occ_d_s;

  // Next-state, issue credit and FIFO bookkeeping.
  always_comb begin
    state_d          = state_q;
    t_len_d          = t_len_q;
    t_idx_d          = t_idx_q;
    core_event_vec_d = core_event_vec_q;
    mem_d            = mem_q;

    issue_s    = ev_valid & ev_ready_q;
    last_s     = (t_idx_q == (t_len_q - T_W'(1)));
    rd_s       = sp_valid_q & sp_ready;
    inflight_s = {1'b0, core_en_q} + {1'b0, cap_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          t_len_d = t_len;
          t_idx_d = '0;
          state_d = (t_len == '0) ? S_DONE : S_CLR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR:   state_d = S_RUN;
      S_RUN: begin
        if (issue_s && last_s) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if ((count_q == '0) && (inflight_s == 2'd0)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (issue_s) begin
      t_idx_d          = t_idx_q + T_W'(1);
      core_event_vec_d = ev_data;
    end else begin
      t_idx_d          = t_idx_d;
      core_event_vec_d = core_event_vec_q;
    end

    // Two-stage shadow of the core: enable cycle, then spike capture cycle.
    core_en_d  = issue_s;
    en_last_d  = issue_s & last_s;
    cap_d      = core_en_q;
    cap_last_d = en_last_q;

    if (cap_q) begin
      mem_d[wr_ptr_q] = {cap_last_q, core_spikes};
    end else begin
      mem_d = mem_d;
    end
    wr_ptr_d = wr_ptr_q + AW'(cap_q);
    rd_ptr_d = rd_ptr_q + AW'(rd_s);
    count_d  = count_q + CW'(cap_q) - CW'(rd_s);

    // Credit counts rows still in the core pipeline so the FIFO cannot overflow.
    inflight_d_s = {1'b0, core_en_d} + {1'b0, cap_d};
    occ_d_s      = {1'b0, count_d} + (CW + 1)'(inflight_d_s);
    ev_ready_d   = (state_d == S_RUN) && (occ_d_s < (CW + 1)'(OFIFO_DEPTH));

    core_clr_d = (state_d == S_CLR);
    busy_d     = (state_d == S_CLR) || (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d     = (state_q == S_DONE);
    sp_valid_d = (count_d != '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= S_IDLE;
      t_len_q          <= '0;
      t_idx_q          <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      ev_ready_q       <= 1'b0;
      core_clr_q       <= 1'b0;
      core_en_q        <= 1'b0;
      core_event_vec_q <= '0;
      en_last_q        <= 1'b0;
      cap_q            <= 1'b0;
      cap_last_q       <= 1'b0;
      for (int i = 0; i < OFIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      sp_valid_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      t_len_q          <= t_len_d;
      t_idx_q          <= t_idx_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      ev_ready_q       <= ev_ready_d;
      core_clr_q       <= core_clr_d;
      core_en_q        <= core_en_d;
      core_event_vec_q <= core_event_vec_d;
      en_last_q        <= en_last_d;
      cap_q            <= cap_d;
      cap_last_q       <= cap_last_d;
      mem_q            <= mem_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      sp_valid_q       <= sp_valid_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign ev_ready       = ev_ready_q;
  assign core_clr       = core_clr_q;
  assign core_en        = core_en_q;
  assign core_event_vec = core_event_vec_q;
  assign sp_valid       = sp_valid_q;
  assign sp_data        = mem_q[rd_ptr_q][N-1:0];
  assign sp_last        = sp_valid_q & mem_q[rd_ptr_q][N];
  assign t_idx          = t_idx_q;

endmodule

// File: tb/tb_snn_step_sequencer.sv
// Directed bench for snn_step_sequencer with a behavioural core that steps only on core_en.
module tb_snn_step_sequencer;

  localparam int F   = 48;
  localparam int N   = 96;
  localparam int T_W = 16;

  logic           clk = 1'b0;
  logic           rstn;
  logic           start;
  logic [T_W-1:0] t_len;
  logic           busy, done;
  logic           ev_valid;
  logic [F-1:0]   ev_data;
  logic           ev_ready;
  logic           core_clr, core_en;
  logic [F-1:0]   core_event_vec;
  logic [N-1:0]   core_spikes;
  logic           sp_valid;
  logic [N-1:0]   sp_data;
  logic           sp_last;
  logic           sp_ready;
  logic [T_W-1:0] t_idx;

  int checks   = 0;
  int failures = 0;

  int           cyc      = 0;
  int           en_cnt   = 0;
  int           done_cnt = 0;
  logic [N:0]   row_q[$];
  int           done_base;

  snn_step_sequencer #(.F(F), .N(N), .T_W(T_W), .OFIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .t_len(t_len), .busy(busy), .done(done),
    .ev_valid(ev_valid), .ev_data(ev_data), .ev_ready(ev_ready),
    .core_clr(core_clr), .core_en(core_en), .core_event_vec(core_event_vec),
    .core_spikes(core_spikes), .sp_valid(sp_valid), .sp_data(sp_data),
    .sp_last(sp_last), .sp_ready(sp_ready), .t_idx(t_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] step_fn(input logic [N-1:0] s, input logic [F-1:0] e);
    return {s[N-2:0], s[N-1]} ^ {e, e};
  endfunction

  function automatic logic [F-1:0] mkvec(input int i);
    logic [31:0] k;
    k = i;
    return {k[15:0] ^ 16'hA5C3, 32'h9E37_79B9 * (k + 32'd1)};
  endfunction

  function automatic logic [N-1:0] golden(input int k);
    logic [N-1:0] s;
    s = '0;
    for (int j = 0; j <= k; j++) s = step_fn(s, mkvec(j));
    return s;
  endfunction

  // Behavioural core: clears on core_clr, advances only when enabled.
  always @(posedge clk) begin
    if (core_clr) core_spikes <= '0;
    else if (core_en) core_spikes <= step_fn(core_spikes, core_event_vec);
  end

  // Monitor: accepted spike rows, enable cycles and done pulses.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sp_valid && sp_ready) row_q.push_back({sp_last, sp_data});
    if (core_en) en_cnt <= en_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic kick(input logic [T_W-1:0] len);
    @(negedge clk);
    start = 1'b1;
    t_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_events(input int first, input int n, input bit gaps, input int budget);
    int idx = first;
    int c = 0;
    bit ph = 1'b0;
    while ((idx < n || done_cnt == done_base) && c < budget) begin
      @(negedge clk);
      c++;
      if (idx < n && (!gaps || !ph)) begin
        ev_valid = 1'b1;
        ev_data  = mkvec(idx);
        if (ev_ready) idx++;
      end else begin
        ev_valid = 1'b0;
      end
      ph = ~ph;
    end
    @(negedge clk);
    ev_valid = 1'b0;
    checks++;
    if (c >= budget) begin
      failures++;
      $display("FAIL run_timeout: issued=%0d required=%0d done_seen=%0d", idx, n, done_cnt - done_base);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; start = 1'b0; t_len = '0; ev_valid = 1'b0; ev_data = '0; sp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, ev_ready, core_clr, core_en, sp_valid, sp_last} !== 7'd0 ||
        core_event_vec !== '0 || t_idx !== '0) begin
      failures++;
      $display("FAIL reset_outputs: ctl=%b vec=%h t_idx=%0d required all zero",
               {busy, done, ev_ready, core_clr, core_en, sp_valid, sp_last}, core_event_vec, t_idx);
    end
    rstn = 1'b1;
  endtask

  task automatic test_basic_run;
    logic [31:0] clr_m = '0, en_m = '0, done_m = '0;
    int idx = 0;
    int rb = row_q.size();
    int db = done_cnt;
    sp_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      clr_m[c]  = core_clr;
      en_m[c]   = core_en;
      done_m[c] = done;
      start = (c == 0);
      t_len = 16'd3;
      if (idx < 3) begin
        ev_valid = 1'b1;
        ev_data  = mkvec(idx);
        if (ev_ready) idx++;
      end else begin
        ev_valid = 1'b0;
      end
    end
    checks++;
    if (clr_m !== 32'h0000_0002) begin
      failures++; $display("FAIL basic_clr_cycles: got=%h required=%h", clr_m, 32'h2);
    end
    checks++;
    if (en_m !== 32'h0000_0038) begin
      failures++; $display("FAIL basic_en_cycles: got=%h required=%h", en_m, 32'h38);
    end
    checks++;
    if (done_m !== 32'h0000_0400) begin
      failures++; $display("FAIL basic_done_cycle: got=%h required=%h", done_m, 32'h400);
    end
    checks++;
    if (row_q.size() - rb !== 3 || done_cnt - db !== 1) begin
      failures++; $display("FAIL basic_counts: rows=%0d done=%0d required 3 and 1", row_q.size() - rb, done_cnt - db);
    end
    for (int i = 0; i < 3 && rb + i < row_q.size(); i++) begin
      checks++;
      if (row_q[rb + i] !== {(i == 2), golden(i)}) begin
        failures++; $display("FAIL basic_row%0d: got=%h required=%h", i, row_q[rb + i], {(i == 2), golden(i)});
      end
    end
    checks++;
    if (t_idx !== 16'd3) begin
      failures++; $display("FAIL basic_t_idx: got=%0d required=3", t_idx);
    end
  endtask

  task automatic test_zero_len;
    logic [7:0] done_m = '0;
    logic activity = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      done_m[c] = done;
      activity  = activity | ev_ready | core_en | sp_valid | busy;
      start = (c == 0);
      t_len = 16'd0;
    end
    checks++;
    if (done_m !== 8'b0000_0100) begin
      failures++; $display("FAIL zero_done_cycle: got=%b required=%b", done_m, 8'b0000_0100);
    end
    checks++;
    if (activity !== 1'b0) begin
      failures++; $display("FAIL zero_activity: got=%b required=0", activity);
    end
  endtask

  task automatic test_backpressure;
    int idx = 0;
    int rb = row_q.size();
    int eb = en_cnt;
    done_base = done_cnt;
    sp_ready = 1'b0;
    kick(16'd8);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      ev_valid = 1'b1;
      ev_data  = mkvec(idx);
      if (ev_ready) idx++;
    end
    checks++;
    if (idx !== 4) begin
      failures++; $display("FAIL bp_issue_count: got=%0d required=4", idx);
    end
    checks++;
    if (ev_ready !== 1'b0 || core_en !== 1'b0 || sp_valid !== 1'b1) begin
      failures++; $display("FAIL bp_stall_state: ev_ready=%b core_en=%b sp_valid=%b required 0 0 1", ev_ready, core_en, sp_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sp_data !== golden(0) || sp_last !== 1'b0) begin
      failures++; $display("FAIL bp_head_stable: got=%h last=%b required=%h last=0", sp_data, sp_last, golden(0));
    end
    sp_ready = 1'b1;
    run_events(idx, 8, 1'b0, 200);
    checks++;
    if (row_q.size() - rb !== 8 || en_cnt - eb !== 8) begin
      failures++; $display("FAIL bp_counts: rows=%0d en=%0d required 8 and 8", row_q.size() - rb, en_cnt - eb);
    end
    for (int i = 0; i < 8 && rb + i < row_q.size(); i++) begin
      checks++;
      if (row_q[rb + i] !== {(i == 7), golden(i)}) begin
        failures++; $display("FAIL bp_row%0d: got=%h required=%h", i, row_q[rb + i], {(i == 7), golden(i)});
      end
    end
  endtask

  task automatic test_gaps;
    int rb = row_q.size();
    int eb = en_cnt;
    done_base = done_cnt;
    sp_ready = 1'b1;
    kick(16'd5);
    run_events(0, 5, 1'b1, 200);
    checks++;
    if (en_cnt - eb !== 5 || row_q.size() - rb !== 5) begin
      failures++; $display("FAIL gaps_counts: en=%0d rows=%0d required 5 and 5", en_cnt - eb, row_q.size() - rb);
    end
    for (int i = 0; i < 5 && rb + i < row_q.size(); i++) begin
      checks++;
      if (row_q[rb + i] !== {(i == 4), golden(i)}) begin
        failures++; $display("FAIL gaps_row%0d: got=%h required=%h", i, row_q[rb + i], {(i == 4), golden(i)});
      end
    end
  endtask

  task automatic test_start_in_run;
    int rb = row_q.size();
    int idx = 0;
    done_base = done_cnt;
    sp_ready = 1'b1;
    kick(16'd4);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      start = 1'b1;
      t_len = 16'd2;
      ev_valid = 1'b1;
      ev_data  = mkvec(idx);
      if (ev_ready) idx++;
    end
    @(negedge clk);
    start = 1'b0;
    ev_valid = 1'b0;
    run_events(idx, 4, 1'b0, 200);
    repeat (4) @(negedge clk);
    checks++;
    if (row_q.size() - rb !== 4 || t_idx !== 16'd4 || done_cnt - done_base !== 1) begin
      failures++; $display("FAIL restart_ignored: rows=%0d t_idx=%0d done=%0d required 4 4 1",
                           row_q.size() - rb, t_idx, done_cnt - done_base);
    end
    for (int i = 0; i < 4 && rb + i < row_q.size(); i++) begin
      checks++;
      if (row_q[rb + i] !== {(i == 3), golden(i)}) begin
        failures++; $display("FAIL restart_row%0d: got=%h required=%h", i, row_q[rb + i], {(i == 3), golden(i)});
      end
    end
  endtask

  task automatic test_reset_midrun;
    int idx = 0;
    int rb;
    int db;
    sp_ready = 1'b0;
    kick(16'd6);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ev_valid = 1'b1;
      ev_data  = mkvec(idx);
      if (ev_ready) idx++;
    end
    db = done_cnt;
    rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done, ev_ready, core_clr, core_en, sp_valid, sp_last} !== 7'd0 ||
        core_event_vec !== '0 || t_idx !== '0) begin
      failures++;
      $display("FAIL midrun_reset: ctl=%b vec=%h t_idx=%0d required all zero",
               {busy, done, ev_ready, core_clr, core_en, sp_valid, sp_last}, core_event_vec, t_idx);
    end
    ev_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (done_cnt !== db) begin
      failures++; $display("FAIL midrun_no_done: got=%0d required=%0d", done_cnt, db);
    end
    rb = row_q.size();
    done_base = done_cnt;
    sp_ready = 1'b1;
    kick(16'd2);
    run_events(0, 2, 1'b0, 200);
    checks++;
    if (row_q.size() - rb !== 2 || done_cnt - done_base !== 1) begin
      failures++; $display("FAIL after_reset_counts: rows=%0d done=%0d required 2 and 1", row_q.size() - rb, done_cnt - done_base);
    end
    for (int i = 0; i < 2 && rb + i < row_q.size(); i++) begin
      checks++;
      if (row_q[rb + i] !== {(i == 1), golden(i)}) begin
        failures++; $display("FAIL after_reset_row%0d: got=%h required=%h", i, row_q[rb + i], {(i == 1), golden(i)});
      end
    end
  endtask

  initial begin
    done_base = 0;
    test_reset();
    test_basic_run();
    test_zero_len();
    test_backpressure();
    test_gaps();
    test_start_in_run();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
